// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads a big-endian 16-bit instruction as two byte
// reads, loads the instruction register and advances the PC; times out on a stalled memory.
module fetch_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              fetch_start,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    input  logic              mem_ready,
    output logic [15:0]       ir_data,
    output logic              ir_load_H,
    output logic              ir_load_L,
    output logic              pc_increase,
    output logic              fetch_done,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_H,
        RD_L,
        DONE,
        ERR
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        wait_q, wait_d;
    logic              err_q, err_d;
    logic              timeout;
    logic [ADDR_W-1:0] readAddr;

    // This cycle is the WAIT_MAX-th consecutive not-ready cycle of the current byte read.
    assign timeout = !mem_ready && (wait_q == WAIT_LAST);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (fetch_start) state_d = RD_H;
                RD_H: begin
                    if (mem_ready)    state_d = RD_L;
                    else if (timeout) state_d = ERR;
                end
                RD_L: begin
                    if (mem_ready)    state_d = DONE;
                    else if (timeout) state_d = ERR;
                end
                DONE:    state_d = IDLE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd      = 1'b0;
        busy        = 1'b0;
        readAddr    = addr_q;
        ir_load_H   = 1'b0;
        ir_load_L   = 1'b0;
        pc_increase = 1'b0;
        fetch_done  = 1'b0;
        case (state_q)
            RD_H: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
            end
            RD_L: begin
                mem_rd   = 1'b1;
                busy     = 1'b1;
                readAddr = addr_q + ADDR_W'(1);
            end
            DONE: begin
                busy        = 1'b1;
                ir_load_H   = !flush;
                ir_load_L   = !flush;
                pc_increase = !flush;
                fetch_done  = !flush;
            end
            default: ;
        endcase
    end

    // The address bus keeps showing the last read address while no read is active.
    assign mem_addr = mem_rd ? readAddr : lastAddr_q;
    assign ir_data  = {hi_q, lo_q};
    assign err      = err_q;

    always_comb begin
        addr_d     = addr_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        wait_d     = wait_q;
        err_d      = err_q;
        lastAddr_d = mem_addr;
        if (flush) begin
            err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_start) begin
                        addr_d = pc_in;
                        wait_d = 8'd0;
                    end
                end
                RD_H: begin
                    if (mem_ready) begin
                        hi_d   = mem_data;
                        wait_d = 8'd0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                        if (timeout) err_d = 1'b1;
                    end
                end
                RD_L: begin
                    if (mem_ready) begin
                        lo_d = mem_data;
                    end else begin
                        wait_d = wait_q + 8'd1;
                        if (timeout) err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            addr_q     <= '0;
            lastAddr_q <= '0;
            hi_q       <= 8'd0;
            lo_q       <= 8'd0;
            wait_q     <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            lastAddr_q <= lastAddr_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

endmodule
